// File: rtl/data_mem_hs_pkg.sv
// rtl/data_mem_hs_pkg.sv - shared data-memory encodings and byte-lane helpers
package cpu_defs;

  // Access size encodings on req_op; 2'b11 is reserved and always errors
  localparam logic [1:0] DM_WORD = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_BYTE = 2'b10;
  localparam logic [1:0] DM_BAD  = 2'b11;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_IDLE  = 1'b1
  } dm_state_e;

  // Byte enables for a store of the given size at the given low address bits
  function automatic logic [3:0] dm_byte_en(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      DM_WORD: dm_byte_en = 4'b1111;
      DM_HALF: dm_byte_en = lo[1] ? 4'b1100 : 4'b0011;
      DM_BYTE: dm_byte_en = 4'b0001 << lo;
      default: dm_byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate the low store bits across the word so every lane sees them
  function automatic logic [31:0] dm_store_lanes(input logic [1:0] op, input logic [31:0] wdata);
    case (op)
      DM_HALF: dm_store_lanes = {2{wdata[15:0]}};
      DM_BYTE: dm_store_lanes = {4{wdata[7:0]}};
      default: dm_store_lanes = wdata;
    endcase
  endfunction

  // Full post-merge word: enabled lanes from new data, others from the old word
  function automatic logic [31:0] dm_merge(input logic [31:0] old_word, input logic [31:0] lanes,
                                           input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      dm_merge[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old_word[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/dm_load_fmt.sv
// rtl/dm_load_fmt.sv - load lane select and sign/zero extension
module dm_load_fmt
  import cpu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  op,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  assign lane_h = addr[1] ? word[31:16] : word[15:0];
  assign lane_b = word[8*addr +: 8];

  // Pick the addressed lane and extend it; WORD passes through untouched
  always_comb begin
    result = '0;
    case (op)
      DM_WORD: result = word;
      DM_HALF: result = {{16{is_signed & lane_h[15]}}, lane_h};
      DM_BYTE: result = {{24{is_signed & lane_b[7]}}, lane_b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - handshaked data memory with clear engine; DM_STORE_LOG_EN enables store logging
module data_mem_hs
  import cpu_defs::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CLEAR_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  dm_state_e     state;
  logic [IW-1:0] clr_ptr;

  logic          acc;
  logic          in_range;
  logic          misal;
  logic          err;
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   lanes;

  logic [31:0]   rd_word;
  logic          rd_ok;
  logic [1:0]    rd_lo;
  logic [1:0]    rd_op;
  logic          rd_sgn;
  logic [31:0]   fmt_word;

  assign acc      = req_valid && req_ready;
  assign idx      = IW'((req_addr - BASE_ADDR) >> 2);
  // BASE_ADDR is window aligned, so range reduces to matching the bits above the window
  assign in_range = (req_addr[31:IW+2] == BASE_ADDR[31:IW+2]);
  assign err      = !in_range || misal;
  assign be       = dm_byte_en(req_op, req_addr[1:0]);
  assign lanes    = dm_store_lanes(req_op, req_wdata);

  // Alignment rule per access size; the reserved op is treated as misaligned
  always_comb begin
    misal = 1'b0;
    case (req_op)
      DM_WORD: misal = |req_addr[1:0];
      DM_HALF: misal = req_addr[0];
      DM_BYTE: misal = 1'b0;
      default: misal = 1'b1;
    endcase
  end

  // Control FSM, handshake and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= (CLEAR_EN != 0) ? DM_CLEAR : DM_IDLE;
      clr_ptr   <= '0;
      req_ready <= 1'b0;
      busy      <= (CLEAR_EN != 0);
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      rd_lo     <= '0;
      rd_op     <= '0;
      rd_sgn    <= 1'b0;
    end else begin
      rsp_valid <= acc;
      rsp_err   <= acc && err;
      rd_ok     <= acc && !err && !req_we;
      if (acc) begin
        rd_lo  <= req_addr[1:0];
        rd_op  <= req_op;
        rd_sgn <= req_signed;
      end
      case (state)
        DM_CLEAR: begin
          clr_ptr <= clr_ptr + IW'(1);
          if (clr_ptr == IW'(DEPTH - 1)) begin
            state     <= DM_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array port: clear writes, byte-lane store merge and registered read; no reset so it maps to RAM
  always_ff @(posedge clk) begin
    if (state == DM_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (acc && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
      end
`ifdef DM_STORE_LOG_EN
      $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, dm_merge(mem[idx], lanes, be));
`endif
    end
    if (acc) rd_word <= mem[idx];
  end

`ifndef DM_STORE_LOG_EN
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  dm_load_fmt u_fmt (
    .word      (rd_word),
    .addr      (rd_lo),
    .op        (rd_op),
    .is_signed (rd_sgn),
    .result    (fmt_word)
  );

  assign rsp_rdata = rd_ok ? fmt_word : '0;

endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - scoreboard bench for data_mem_hs with a byte-array reference model
module tb_data_mem_hs;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_op;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    int          stamp;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  byte unsigned ref_mem [4*DEPTH];
  int          cyc;
  int          n_chk;
  int          n_fail;

  data_mem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CLEAR_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory is a byte array; sizes, alignment and range come straight from the rules
  function automatic void model(input logic we, input logic [1:0] op, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    longint a = longint'(addr);
    longint b = longint'(BASE);
    int size;
    int off;
    logic [31:0] v;
    size  = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 0;
    rdata = '0;
    err   = (a < b) || (a >= b + 4 * DEPTH) || (size == 0);
    if (!err && (a % size) != 0) err = 1'b1;
    if (err) return;
    off = int'(a - b);
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[off + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[off + i];
      if (sgn && size < 4 && v[8*size - 1]) begin
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rdata = v;
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // Drive one request, predict its response and queue it for the monitor
  task automatic issue(input string name, input logic we, input logic [1:0] op, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got req_ready 0 expected 1", name);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_op     = op;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = $urandom;
    model(we, op, sgn, addr, wdata, e.rdata, e.err);
    e.stamp = cyc + 1;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count busy cycles after reset release; ready must stay low throughout
  task automatic wait_clear(input string name);
    int cnt = 0;
    int bad = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (req_ready) bad++;
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
    chk({name, "_ready_while_busy"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({name, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({name, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  // Monitor: every response must match the oldest prediction, one cycle after its accept
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0 (rdata %h)", rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.stamp));
        chk({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end else if (sb.size() != 0 && sb[0].stamp <= cyc) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s_missing: got rsp_valid 0 expected 1", mon_e.name);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  op;
    int          r;
    cyc        = 0;
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_op     = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_pc     = '0;
    clear_model();

    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clear("clear0");
    @(posedge clk);
    #1;

    issue("t1_load_w0", 1'b0, 2'b00, 1'b0, BASE, 32'h0);

    issue("t2_store_w", 1'b1, 2'b00, 1'b0, BASE + 4, 32'h8899_AABB);
    issue("t2_lb_s", 1'b0, 2'b10, 1'b1, BASE + 5, 32'h0);
    issue("t2_lb_u", 1'b0, 2'b10, 1'b0, BASE + 5, 32'h0);

    issue("t3_store_h", 1'b1, 2'b01, 1'b0, BASE + 6, 32'hDEAD_1234);
    issue("t3_load_w", 1'b0, 2'b00, 1'b0, BASE + 4, 32'h0);

    issue("t4_lw_misal", 1'b0, 2'b00, 1'b0, BASE + 2, 32'h0);
    issue("t4_sh_misal", 1'b1, 2'b01, 1'b0, BASE + 1, 32'hFFFF_FFFF);
    issue("t4_load_w", 1'b0, 2'b00, 1'b0, BASE, 32'h0);
    issue("t4_lh_s", 1'b0, 2'b01, 1'b1, BASE + 4, 32'h0);

    issue("t5_above", 1'b0, 2'b00, 1'b0, BASE + 4 * DEPTH, 32'h0);
    issue("t5_below", 1'b1, 2'b00, 1'b0, BASE - 4, 32'h1111_2222);
    issue("t5_badop", 1'b0, 2'b11, 1'b0, BASE, 32'h0);
    issue("t5_last_st", 1'b1, 2'b00, 1'b0, BASE + 4 * DEPTH - 4, 32'hCAFE_F00D);
    issue("t5_last_ld", 1'b0, 2'b10, 1'b1, BASE + 4 * DEPTH - 1, 32'h0);

    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 2));
      r = $urandom_range(0, 15);
      if (r == 0)      addr = BASE + 4 * DEPTH + $urandom_range(0, 7);
      else if (r == 1) addr = BASE - $urandom_range(1, 8);
      else             addr = BASE + $urandom_range(0, 4 * DEPTH - 1);
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 2'b00) addr[1:0] = 2'b00;
        if (op == 2'b01) addr[0] = 1'b0;
      end
      issue("rnd", 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    idle(3);
    chk("rnd_drained", 32'(sb.size()), 32'd0);

    issue("t6_store", 1'b1, 2'b00, 1'b0, BASE + 8, 32'h7654_3210);
    issue("t6_load", 1'b0, 2'b00, 1'b0, BASE + 8, 32'h0);
    chk("t6_pre_valid", {31'b0, rsp_valid}, 32'd1);
    #1;
    reset = 1'b1;
    sb.delete();
    clear_model();
    #1;
    chk_reset_outputs("t6_mid_rsp");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    reset = 1'b1;
    #1;
    chk_reset_outputs("t6_mid_clear");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clear("clear2");
    @(posedge clk);
    #1;
    issue("t6_after_w8", 1'b0, 2'b00, 1'b0, BASE + 8, 32'h0);
    issue("t6_after_w4", 1'b0, 2'b00, 1'b0, BASE + 4, 32'h0);
    issue("t6_after_last", 1'b0, 2'b00, 1'b0, BASE + 4 * DEPTH - 4, 32'h0);

    idle(3);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
